fp_add_align: RTL and testbench
===============================

// Module: fp_add_align
// PURPOSE
//  Operand-alignment front end of the single-precision FP adder. Unpacks two IEEE-754 operands,
//  orders them by magnitude, computes the exponent difference as a saturated 5-bit shift amount,
//  and hands {MANT_S, SHAMT} to the 24-bit right barrel shifter (shiftright.DI/.sel).
//  Two-stage registered pipeline with valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W  8   exponent width
//  MAN_W  23  stored fraction width; datapath mantissa is MAN_W+1 = 24 bits (hidden bit)
//  SH_W   5   shift-amount width; must match the shifter select width
// PORTS
//  clk       in   1   clock, all state on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  in_valid  in   1   A/B valid
//  in_ready  out  1   block accepts A/B this cycle
//  A         in   32  operand A, IEEE-754 single
//  B         in   32  operand B, IEEE-754 single
//  out_valid out  1   outputs valid
//  out_ready in   1   downstream accepts outputs
//  SIGN_L    out  1   sign of larger-magnitude operand
//  SIGN_S    out  1   sign of smaller-magnitude operand
//  EFF_SUB   out  1   SIGN_L ^ SIGN_S (effective subtraction)
//  EXP_L     out  8   biased exponent of larger operand
//  MANT_L    out  24  {hidden, fraction} of larger operand
//  MANT_S    out  24  {hidden, fraction} of smaller operand (unshifted)
//  SHAMT     out  5   min(EXP_L - EXP_S, 31); feeds shifter sel
//  SPECIAL   out  1   either operand has exponent 8'hFF (Inf/NaN); datapath fields still produced
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valid bits 0; out_valid=0; all data outputs 0.
//    in_ready is 1 while the pipe is empty. Reset mid-operation discards in-flight operands.
//  - Unpack (stage 1, registered on accept): exp==0 -> operand flushed to zero: mantissa 24'h0,
//    exponent 0 (no denormal support). Else mantissa = {1'b1, frac}. Stage 1 also registers
//    diff_ab = {1'b0,expA}-{1'b0,expB} (9-bit signed) and mantissa compare mA>=mB.
//  - Order (stage 2): A is "L" if expA>expB, or expA==expB and mA>=mB; otherwise B is "L".
//    Tie on equal magnitude selects A. Guarantees MANT_L>=MANT_S when SHAMT==0.
//  - SHAMT = |diff_ab| saturated to 31 (diff>=31 -> 5'd31; shifter then yields 0 for 24-bit data).
//  - Latency: 2 cycles from accepted input to out_valid when out_ready stays 1; throughput 1/cycle.
//  - Handshake: transfer on valid&&ready at each side. adv2 = !v2 || out_ready;
//    adv1 = !v1 || adv2; in_ready = adv1 (combinational, no dependency on in_valid).
//    Output fields are held stable while out_valid=1 and out_ready=0.
//    in_valid may drop without a transfer; out_valid never drops without a transfer.
//  - Full pipe + out_ready=0: in_ready=0, no operand lost or duplicated; order preserved.
//  - Simultaneous out transfer and in accept with full pipe: both stages advance the same cycle.
//  - No combinational path from A/B to any output.
// TESTING
//  1. A=3F800000, B=3F000000 (1.0+0.5) -> after 2 cyc: EXP_L=7F, MANT_L=800000, MANT_S=800000,
//     SHAMT=1, EFF_SUB=0, SIGN_L=0.
//  2. A=3F000000, B=C0000000 (0.5,-2.0) -> swap: SIGN_L=1, SIGN_S=0, EXP_L=80, SHAMT=2, EFF_SUB=1.
//  3. Equal exp: A=3FC00000 (1.5), B=BFE00000 (-1.75) -> L=B: MANT_L=E00000, MANT_S=C00000,
//     SHAMT=0; A=B=3F800000 -> L=A, SIGN_L=SIGN_S=0.
//  4. Range/specials: A=7E800000, B=3F800000 -> SHAMT=31 (saturated); A=00400000 (denormal) ->
//     MANT=000000; A=7F800000 -> SPECIAL=1.
//  5. Backpressure: stream 6 back-to-back operand pairs, out_ready=0 for cycles 2..8 -> in_ready=0
//     after 2 accepts, all 6 results emerge in order, outputs stable while stalled.
//  6. Assert rst_n=0 for 1 cycle with 2 operands in flight -> out_valid=0 immediately, outputs 0,
//     in_ready=1; next operand after release appears 2 cycles after accept.

Source files
------------

// File: rtl/fp_add_align_if.sv
// Handshake and data bundle for the FP adder alignment front end.
// Input side (A/B) and output side (aligned fields) share one interface.
interface fp_add_align_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SH_W  = 5
);
  localparam int DW = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    A;
  logic [DW-1:0]    B;
  logic             out_valid;
  logic             out_ready;
  logic             SIGN_L;
  logic             SIGN_S;
  logic             EFF_SUB;
  logic [EXP_W-1:0] EXP_L;
  logic [MAN_W:0]   MANT_L;
  logic [MAN_W:0]   MANT_S;
  logic [SH_W-1:0]  SHAMT;
  logic             SPECIAL;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, SIGN_L, SIGN_S, EFF_SUB, EXP_L, MANT_L, MANT_S, SHAMT, SPECIAL
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, SIGN_L, SIGN_S, EFF_SUB, EXP_L, MANT_L, MANT_S, SHAMT, SPECIAL
  );
endinterface

// File: rtl/fp_add_align.sv
// Two-stage alignment front end: stage 1 unpacks A/B, stage 2 orders by magnitude
// and produces the saturated shift amount for the mantissa right shifter.
module fp_add_align #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SH_W  = 5
) (
  input logic            clk,
  input logic            rst_n,
  fp_add_align_if.slave  bus
);
  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam logic [EXP_W:0] SH_SAT = (EXP_W+1)'((1 << SH_W) - 1);

  logic w_adv1, w_adv2;
  logic r_v1, r_v2;

  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MW-1:0]    w_ma, w_mb;
  logic             w_spec;

  logic                   r_sa, r_sb, r_spec1, r_ma_ge;
  logic [EXP_W-1:0]       r_ea, r_eb;
  logic [MW-1:0]          r_ma, r_mb;
  logic signed [EXP_W:0]  r_diff;

  logic            w_a_is_l;
  logic [EXP_W:0]  w_abs;
  logic [SH_W-1:0] w_shamt;

  logic             r_sign_l, r_sign_s, r_eff_sub, r_special;
  logic [EXP_W-1:0] r_exp_l;
  logic [MW-1:0]    r_mant_l, r_mant_s;
  logic [SH_W-1:0]  r_shamt;

  assign w_adv2       = !r_v2 || bus.out_ready;
  assign w_adv1       = !r_v1 || w_adv2;
  assign bus.in_ready = w_adv1;

  // Zero exponent flushes the operand to zero; denormals are not supported.
  always_comb begin
    w_ea   = bus.A[DW-2 -: EXP_W];
    w_eb   = bus.B[DW-2 -: EXP_W];
    w_ma   = (w_ea == '0) ? '0 : {1'b1, bus.A[MAN_W-1:0]};
    w_mb   = (w_eb == '0) ? '0 : {1'b1, bus.B[MAN_W-1:0]};
    w_spec = (&w_ea) || (&w_eb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_spec1 <= 1'b0;
      r_ma_ge <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_diff  <= '0;
    end else if (w_adv1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_sa    <= bus.A[DW-1];
        r_sb    <= bus.B[DW-1];
        r_spec1 <= w_spec;
        r_ma_ge <= (w_ma >= w_mb);
        r_ea    <= w_ea;
        r_eb    <= w_eb;
        r_ma    <= w_ma;
        r_mb    <= w_mb;
        r_diff  <= $signed({1'b0, w_ea} - {1'b0, w_eb});
      end
    end
  end

  // Equal magnitudes pick A as the larger operand.
  always_comb begin
    w_a_is_l = (r_diff > 0) || ((r_diff == 0) && r_ma_ge);
    w_abs    = r_diff[EXP_W] ? $unsigned(-r_diff) : $unsigned(r_diff);
    w_shamt  = (w_abs >= SH_SAT) ? SH_SAT[SH_W-1:0] : w_abs[SH_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_sign_l  <= 1'b0;
      r_sign_s  <= 1'b0;
      r_eff_sub <= 1'b0;
      r_special <= 1'b0;
      r_exp_l   <= '0;
      r_mant_l  <= '0;
      r_mant_s  <= '0;
      r_shamt   <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign_l  <= w_a_is_l ? r_sa : r_sb;
        r_sign_s  <= w_a_is_l ? r_sb : r_sa;
        r_eff_sub <= r_sa ^ r_sb;
        r_special <= r_spec1;
        r_exp_l   <= w_a_is_l ? r_ea : r_eb;
        r_mant_l  <= w_a_is_l ? r_ma : r_mb;
        r_mant_s  <= w_a_is_l ? r_mb : r_ma;
        r_shamt   <= w_shamt;
      end
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.SIGN_L    = r_sign_l;
  assign bus.SIGN_S    = r_sign_s;
  assign bus.EFF_SUB   = r_eff_sub;
  assign bus.EXP_L     = r_exp_l;
  assign bus.MANT_L    = r_mant_l;
  assign bus.MANT_S    = r_mant_s;
  assign bus.SHAMT     = r_shamt;
  assign bus.SPECIAL   = r_special;
endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: driver pushes model results at accept time,
// a negedge monitor pops and compares whenever an output transfer is about to occur.
module tb_fp_add_align;
  typedef struct packed {
    logic        sl;
    logic        ss;
    logic        es;
    logic [7:0]  el;
    logic [23:0] ml;
    logic [23:0] ms;
    logic [4:0]  sh;
    logic        sp;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
    bit   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fp_add_align_if u_if ();

  fp_add_align u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   rand_rdy = 1'b0;
  bit   held = 1'b0;
  res_t hold_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Reference: magnitude ordering by (exponent, mantissa) as one integer key.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    int ea, eb, d;
    longint ma, mb, ka, kb;
    bit a_l;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    ka = longint'(ea) * 16777216 + ma;
    kb = longint'(eb) * 16777216 + mb;
    a_l = (ka >= kb);
    d = ea - eb;
    if (d < 0) d = -d;
    if (d > 31) d = 31;
    r.sl = a_l ? a[31] : b[31];
    r.ss = a_l ? b[31] : a[31];
    r.es = a[31] ^ b[31];
    r.el = 8'(a_l ? ea : eb);
    r.ml = 24'(a_l ? ma : mb);
    r.ms = 24'(a_l ? mb : ma);
    r.sh = 5'(d);
    r.sp = (ea == 255) || (eb == 255);
    return r;
  endfunction

  function automatic res_t actual();
    res_t r;
    r.sl = u_if.SIGN_L;
    r.ss = u_if.SIGN_S;
    r.es = u_if.EFF_SUB;
    r.el = u_if.EXP_L;
    r.ml = u_if.MANT_L;
    r.ms = u_if.MANT_S;
    r.sh = u_if.SHAMT;
    r.sp = u_if.SPECIAL;
    return r;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n && u_if.out_valid) begin
      res_t act;
      act = actual();
      if (u_if.out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", $sformatf("got %h with empty scoreboard", act));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          chk(act == e.r, "result", $sformatf("#%0d got %h required %h", n_out, act, e.r));
          $display("out #%0d: sl=%0b ss=%0b es=%0b el=%h ml=%h ms=%h sh=%0d sp=%0b", n_out,
                   act.sl, act.ss, act.es, act.el, act.ml, act.ms, act.sh, act.sp);
          if (e.lat)
            chk(cyc - e.cyc == 2, "latency", $sformatf("got %0d required 2", cyc - e.cyc));
        end
      end else begin
        if (held) chk(act == hold_val, "stall_stable", $sformatf("got %h required %h", act, hold_val));
        hold_val = act;
        held = 1'b1;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Randomised backpressure, enabled only for the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) u_if.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit lat);
    bit acc;
    int n;
    exp_t e;
    n = 0;
    u_if.A = a;
    u_if.B = b;
    u_if.in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = u_if.in_ready;
      if (acc) begin
        e.r = model(a, b);
        e.cyc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
      end
      tick();
      n++;
      if (!acc && n > 300) begin
        chk(1'b0, "accept_timeout", $sformatf("in_ready stuck 0 for %0d cycles", n));
        acc = 1'b1;
      end
    end while (!acc);
    u_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk(exp_q.size() == 0, "drain", $sformatf("%0d results outstanding, required 0", exp_q.size()));
  endtask

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    logic [31:0] b;
    int e;
    b = $urandom;
    case ($urandom_range(0, 4))
      0: ;
      1: b[30:23] = a[30:23];
      2: begin
        e = int'(a[30:23]) + $urandom_range(0, 80) - 40;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        b[30:23] = 8'(e);
      end
      3: b = {~a[31], a[30:0]};
      default: b[30:23] = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
    endcase
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    u_if.in_valid = 1'b0;
    u_if.A = '0;
    u_if.B = '0;
    u_if.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk(u_if.out_valid == 1'b0, "reset_out_valid", $sformatf("got %0b required 0", u_if.out_valid));
    chk(u_if.in_ready == 1'b1, "reset_in_ready", $sformatf("got %0b required 1", u_if.in_ready));
    chk(actual() == '0, "reset_data", $sformatf("got %h required 0", actual()));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors, isolated so latency is exactly 2
    send(32'h3F800000, 32'h3F000000, 1'b1); repeat (3) tick();
    send(32'h3F000000, 32'hC0000000, 1'b1); repeat (3) tick();
    send(32'h3FC00000, 32'hBFE00000, 1'b1); repeat (3) tick();
    send(32'h3F800000, 32'h3F800000, 1'b1); repeat (3) tick();
    send(32'h7E800000, 32'h3F800000, 1'b1); repeat (3) tick();
    send(32'h00400000, 32'h3F800000, 1'b1); repeat (3) tick();
    send(32'h7F800000, 32'h3F800000, 1'b1); repeat (3) tick();
    send(32'h80000000, 32'h00000000, 1'b1); repeat (3) tick();
    drain();

    // Backpressure: 6 back-to-back pairs with output stalled
    u_if.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'b0);
      end
      begin
        repeat (3) tick();
        @(negedge clk);
        chk(u_if.in_ready == 1'b0, "full_in_ready", $sformatf("got %0b required 0", u_if.in_ready));
        chk(u_if.out_valid == 1'b1, "full_out_valid", $sformatf("got %0b required 1", u_if.out_valid));
        repeat (4) tick();
        u_if.out_ready = 1'b1;
      end
    join
    drain();

    // Async reset with two operands in flight
    u_if.out_ready = 1'b0;
    send(32'h40400000, 32'h3F800000, 1'b0);
    send(32'hC1200000, 32'h40000000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk(u_if.out_valid == 1'b0, "rst_mid_out_valid", $sformatf("got %0b required 0", u_if.out_valid));
    chk(u_if.in_ready == 1'b1, "rst_mid_in_ready", $sformatf("got %0b required 1", u_if.in_ready));
    chk(actual() == '0, "rst_mid_data", $sformatf("got %h required 0", actual()));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    tick();
    send(32'h41000000, 32'hBF800000, 1'b1);
    repeat (3) tick();
    drain();

    // Random stream with random gaps and backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      send(a, rand_b(a), 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    tick();
    u_if.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
